// File: rtl/data_axi_bridge.sv
// Memory-stage data port to AXI-lite bridge; one transaction in flight (IDLE/AR/R/AWW/B).
// Latency: read completion pulse 3 cycles after accept with zero-wait slave; write adds the B phase.
// Backpressure: requests are stalled (data_addr_ok=0) until the bridge is idle; build option DATA_BRIDGE_POSTED_WRITE_EN.
module data_axi_bridge #(
    parameter int ADDR_ALIGN_READ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ok_q, ok_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        accept_c;
    logic        aw_fin, w_fin;
    logic [3:0]  strb_c;

    always_comb begin
        case (data_size)
            2'b00:   strb_c = 4'b0001 << data_addr[1:0];
            2'b01:   strb_c = 4'b0011 << {data_addr[1], 1'b0};
            default: strb_c = 4'b1111;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        ok_d      = 1'b0;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        accept_c  = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        aw_fin    = 1'b0;
        w_fin     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    accept_c  = 1'b1;
                    addr_d    = data_addr;
                    wdata_d   = data_wdata;
                    wstrb_d   = strb_c;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = data_wr ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    ok_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_AWW: begin
                // AW and W channels retire independently; leave only once both are done.
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_fin    = aw_done_q | awready;
                w_fin     = w_done_q | wready;
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    state_d = S_B;
`ifdef DATA_BRIDGE_POSTED_WRITE_EN
                    ok_d    = 1'b1;
`endif
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = S_IDLE;
`ifndef DATA_BRIDGE_POSTED_WRITE_EN
                    ok_d    = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            ok_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            ok_q      <= ok_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Reset gates the accept strobe so a request held during reset is never acknowledged.
    assign data_addr_ok = accept_c & rst;
    assign data_data_ok = ok_q;
    assign data_rdata   = rdata_q;
    assign araddr       = (ADDR_ALIGN_READ != 0) ? {addr_q[31:2], 2'b00} : addr_q;
    assign awaddr       = {addr_q[31:2], 2'b00};
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: vector table of single transactions plus reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_data_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    data_axi_bridge dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          da, dw, db;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        int          lat_np, lat_p;
    } vec_t;

    int          ok_c[2];
    int          ok_n, acc2, b_cyc;
    logic        seen_ar, seen_aw;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [31:0] r_dat[2];
    logic [3:0]  s_wstrb;

    task automatic clear_bus();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rdata = '0;
    endtask

    // One request; the slave model answers after da/dw/db wait cycles (read: da=AR, dw=R).
    // With hold set, a word read to h_addr is held pending right behind the first request.
    task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input int da, input int dw, input int db,
                           input logic hold, input logic [31:0] h_addr, input logic [31:0] h_rdata);
        int cyc, need, ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, cur_da, cur_dr;
        logic [31:0] rresp;
        logic done, b_done;
        ok_n = 0; acc2 = -1; b_cyc = -1; ok_c[0] = -1; ok_c[1] = -1;
        seen_ar = 1'b0; seen_aw = 1'b0; s_araddr = '0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
        r_dat[0] = '0; r_dat[1] = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        need   = hold ? 2 : 1;
        cur_da = wr ? 0 : da;
        cur_dr = wr ? 0 : dw;
        rresp  = wr ? h_rdata : data;
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = data;
        @(negedge clk);
        chk("accept", 32'(data_addr_ok), 32'd1);
        cyc = 0; done = 1'b0; b_done = !wr;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                if (hold) begin
                    data_wr = 1'b0; data_size = 2'b10; data_addr = h_addr; data_wdata = '0;
                end else begin
                    data_req = 1'b0;
                end
            end else if (acc2 >= 0 && cyc == acc2 + 1) begin
                data_req = 1'b0;
            end
            @(negedge clk);
            if (data_data_ok) begin
                if (ok_n < 2) begin
                    ok_c[ok_n]  = cyc;
                    r_dat[ok_n] = data_rdata;
                end
                ok_n++;
            end
            if (hold && acc2 < 0 && data_addr_ok) begin
                acc2 = cyc; cur_da = 0; cur_dr = 0; rresp = h_rdata;
            end
            if (arvalid && !seen_ar) begin seen_ar = 1'b1; s_araddr = araddr; end
            arready = arvalid && (ar_cnt >= cur_da);
            if (arvalid) ar_cnt = arready ? 0 : ar_cnt + 1;
            rvalid = rready && (r_cnt >= cur_dr);
            rdata  = rvalid ? rresp : 32'h0;
            if (rready) r_cnt = rvalid ? 0 : r_cnt + 1;
            if (awvalid && !seen_aw) begin seen_aw = 1'b1; s_awaddr = awaddr; end
            if (wvalid) begin s_wdata = wdata; s_wstrb = wstrb; end
            awready = awvalid && (aw_cnt >= da);
            if (awvalid) aw_cnt = awready ? 0 : aw_cnt + 1;
            wready = wvalid && (w_cnt >= dw);
            if (wvalid) w_cnt = wready ? 0 : w_cnt + 1;
            bvalid = bready && (b_cnt >= db);
            if (bvalid && b_cyc < 0) begin b_cyc = cyc; b_done = 1'b1; end
            if (bready) b_cnt = bvalid ? 0 : b_cnt + 1;
            if (ok_n >= need && b_done) done = 1'b1;
            if (cyc > 60) begin
                checks++; failures++;
                $display("FAIL txn_timeout: got ok_n=%0d b_done=%0d expected completion within 60 cycles", ok_n, b_done);
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("ok_single_pulse", 32'(data_data_ok), 32'd0);
        chk("ok_count", 32'(ok_n), 32'(need));
        clear_bus();
        data_req = 1'b0;
    endtask

    vec_t        vecs[10];
    int          exp_lat;
    logic [31:0] last_rd;
    logic        posted;

    initial begin
`ifdef DATA_BRIDGE_POSTED_WRITE_EN
        posted = 1'b1;
`else
        posted = 1'b0;
`endif
        vecs[0] = '{1'b0, 2'b10, 32'h1FC00004, 32'hDEADBEEF, 0, 0, 0, 32'h1FC00004, 4'h0, 3, 3};
        vecs[1] = '{1'b0, 2'b00, 32'h1FC00006, 32'h12345678, 1, 2, 0, 32'h1FC00004, 4'h0, 6, 6};
        vecs[2] = '{1'b0, 2'b00, 32'h00000001, 32'hA5A5A5A5, 2, 0, 0, 32'h00000000, 4'h0, 5, 5};
        vecs[3] = '{1'b1, 2'b00, 32'h00000003, 32'h5A5A5A5A, 2, 0, 0, 32'h00000000, 4'b1000, 5, 4};
        vecs[4] = '{1'b1, 2'b00, 32'h00000001, 32'h11111111, 0, 0, 0, 32'h00000000, 4'b0010, 3, 2};
        vecs[5] = '{1'b1, 2'b01, 32'h00000002, 32'hBEEFBEEF, 0, 3, 1, 32'h00000000, 4'b1100, 7, 5};
        vecs[6] = '{1'b1, 2'b01, 32'h00001001, 32'h33333333, 0, 0, 0, 32'h00001000, 4'b0011, 3, 2};
        vecs[7] = '{1'b1, 2'b10, 32'h80000007, 32'hCAFEF00D, 1, 1, 0, 32'h80000004, 4'b1111, 4, 3};
        vecs[8] = '{1'b1, 2'b11, 32'h00000022, 32'h44444444, 0, 0, 2, 32'h00000020, 4'b1111, 5, 2};
        vecs[9] = '{1'b0, 2'b11, 32'hFFFFFFFF, 32'h0BADF00D, 0, 0, 0, 32'hFFFFFFFC, 4'h0, 3, 3};

        // Reset state with a request already pending.
        data_req = 1'b1;
        #12;
        @(negedge clk);
        chk("rst_handshakes", 32'({arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}), 32'd0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_wstrb", 32'(wstrb), 32'h0);
        chk("rst_rdata", data_rdata, 32'h0);
        data_req = 1'b0;
        rst = 1'b1;

        // Stray slave responses while idle must be ignored.
        arready = 1'b1; rvalid = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1; rdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ignore", 32'({arvalid, rready, awvalid, wvalid, bready, data_data_ok}), 32'd0);
        end
        chk("idle_rdata", data_rdata, 32'h0);
        clear_bus();

        last_rd = '0;
        for (int i = 0; i < 10; i++) begin
            exp_lat = posted ? vecs[i].lat_p : vecs[i].lat_np;
            run_txn(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].data,
                    vecs[i].da, vecs[i].dw, vecs[i].db, 1'b0, 32'h0, 32'h0);
            chk($sformatf("v%0d_latency", i), 32'(ok_c[0]), 32'(exp_lat));
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_awaddr", i), s_awaddr, vecs[i].exp_addr);
                chk($sformatf("v%0d_wstrb", i), 32'(s_wstrb), 32'(vecs[i].exp_strb));
                chk($sformatf("v%0d_wdata", i), s_wdata, vecs[i].data);
                chk($sformatf("v%0d_no_ar", i), 32'(seen_ar), 32'd0);
                chk($sformatf("v%0d_rdata_hold", i), data_rdata, last_rd);
            end else begin
                chk($sformatf("v%0d_araddr", i), s_araddr, vecs[i].exp_addr);
                chk($sformatf("v%0d_rdata", i), r_dat[0], vecs[i].data);
                chk($sformatf("v%0d_no_aw", i), 32'(seen_aw), 32'd0);
                last_rd = vecs[i].data;
            end
        end

        // Half write with a read held pending behind it.
        run_txn(1'b1, 2'b01, 32'h00000002, 32'h77777777, 0, 0, 0, 1'b1, 32'h00000104, 32'h13572468);
        chk("b2b_wstrb", 32'(s_wstrb), 32'(4'b1100));
        chk("b2b_accept_cycle", 32'(acc2), 32'd3);
        chk("b2b_write_ok", 32'(ok_c[0]), posted ? 32'd2 : 32'd3);
        chk("b2b_read_ok", 32'(ok_c[1]), 32'd6);
        chk("b2b_araddr", s_araddr, 32'h00000104);
        chk("b2b_rdata", r_dat[1], 32'h13572468);

        // Word write with slow B response and a read held pending behind it.
        run_txn(1'b1, 2'b10, 32'h00000100, 32'h24681357, 0, 0, 5, 1'b1, 32'h00000200, 32'h89ABCDEF);
        chk("slowb_bvalid_cycle", 32'(b_cyc), 32'd7);
        chk("slowb_accept_cycle", 32'(acc2), 32'd8);
        chk("slowb_write_ok", 32'(ok_c[0]), posted ? 32'd2 : 32'd8);
        chk("slowb_read_ok", 32'(ok_c[1]), 32'd11);
        chk("slowb_rdata", r_dat[1], 32'h89ABCDEF);

        // Reset while in R with the read response still pending.
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h00000040;
        @(negedge clk);
        chk("mid_accept", 32'(data_addr_ok), 32'd1);
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        chk("mid_arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        @(negedge clk);
        chk("mid_rready", 32'(rready), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_handshakes", 32'({arvalid, rready, data_data_ok, data_addr_ok}), 32'd0);
        chk("mid_rst_araddr", araddr, 32'h0);
        chk("mid_rst_rdata", data_rdata, 32'h0);
        rvalid = 1'b1; rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_no_ok", 32'({rready, data_data_ok}), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({rready, data_data_ok}), 32'd0);
        end
        clear_bus();
        chk("post_rst_rdata", data_rdata, 32'h0);
        run_txn(1'b0, 2'b10, 32'h00000044, 32'h600DF00D, 0, 0, 0, 1'b0, 32'h0, 32'h0);
        chk("post_rst_latency", 32'(ok_c[0]), 32'd3);
        chk("post_rst_araddr", s_araddr, 32'h00000044);
        chk("post_rst_read", r_dat[0], 32'h600DF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before 400us");
        $fatal(1);
    end

endmodule

// File: doc/data_axi_bridge.md
DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
REQ-001 Parameter: ADDR_ALIGN_READ, default 1, meaning araddr is forced word-aligned ({addr[31:2],2'b00}) when 1 and passed unmodified when 0.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert is the system's duty.
REQ-004 data_req  in  1  request from the memory stage.
REQ-005 data_wr  in  1  1 = write, 0 = read.
REQ-006 data_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-007 data_addr  in  32  physical byte address.
REQ-008 data_wdata  in  32  write data, already lane-replicated.
REQ-009 data_addr_ok  out  1  request accepted this cycle.
REQ-010 data_data_ok  out  1  one-cycle completion pulse.
REQ-011 data_rdata  out  32  read word, valid while data_data_ok=1.
REQ-012 araddr  out  32;  arvalid  out  1;  arready  in  1  (AXI-lite read address).
REQ-013 rdata  in  32;  rvalid  in  1;  rready  out  1  (read data).
REQ-014 awaddr  out  32;  awvalid  out  1;  awready  in  1  (write address, always word-aligned).
REQ-015 wdata  out  32;  wstrb  out  4;  wvalid  out  1;  wready  in  1  (write data).
REQ-016 bvalid  in  1;  bready  out  1  (write response; response code ignored).

Function
REQ-017 FSM states are IDLE, AR, R, AWW and B; exactly one transaction is outstanding at any time.
REQ-018 data_addr_ok SHALL equal data_req && state==IDLE; on acceptance addr/wr/size/wdata are captured and the FSM goes to AR (read) or AWW (write).
REQ-019 Captured fields SHALL drive the bus; data_* inputs are don't-care outside the accept cycle.
REQ-020 AR: arvalid=1 until arready, then R; R: rready=1, and on rvalid rdata is registered into data_rdata and the FSM returns to IDLE.
REQ-021 AWW: awvalid and wvalid assert together, each deasserts independently after its own handshake; when both have completed (same or different cycles) the FSM goes to B.
REQ-022 B: bready=1; on bvalid the FSM returns to IDLE.
REQ-023 data_data_ok SHALL be a registered pulse one cycle after the completing R or B handshake, lasting exactly one cycle; data_rdata holds until the next read completes.
REQ-024 Minimum read latency: accept at cycle 0, arvalid at cycle 1, data_data_ok at cycle 3 when arready and rvalid each respond immediately.
REQ-025 wstrb: size 00 gives 4'b0001<<addr[1:0]; 01 gives 4'b0011<<{addr[1],1'b0}; 10 and 11 give 4'b1111.
REQ-026 A request may be accepted in the same cycle data_data_ok is high (back-to-back requests).
REQ-027 Bus inputs that arrive in a state that does not expect them (for example rvalid in IDLE) SHALL be ignored; no ready is raised for them.

Reset
REQ-028 With rst=0, the block SHALL immediately force state=IDLE, force all valid/ready outputs and data_addr_ok/data_data_ok to 0, and force data_rdata, araddr, awaddr, wdata and wstrb to 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction, with no data_data_ok pulse, and the first request after reset SHALL be accepted normally.

Configuration
REQ-030 With DATA_BRIDGE_POSTED_WRITE_EN defined, write data_data_ok SHALL pulse one cycle after both AW and W handshakes complete (on entry to B). data_addr_ok stays 0 until bvalid is received.
REQ-031 Without DATA_BRIDGE_POSTED_WRITE_EN, writes SHALL complete only per REQ-023 (after B).

Verification
REQ-032 Read word at 0x1FC00004, arready=1, rvalid=1 at the first rready with rdata=0xDEADBEEF -> araddr=0x1FC00004, data_data_ok at cycle 3, data_rdata=0xDEADBEEF.
REQ-033 Byte write at 0x00000003 with data 0x5A5A5A5A, awready 2 cycles late, wready immediate -> wstrb=4'b1000, awaddr=0x00000000, single data_data_ok one cycle after bvalid.
REQ-034 Half write at 0x00000002 -> wstrb=4'b1100; a second read request held high during B -> data_addr_ok=0 until the cycle of data_data_ok.
REQ-035 Reset asserted while in R with rvalid pending -> arvalid/rready=0 immediately, no data_data_ok, and a following read completes with correct data.
REQ-036 POSTED_WRITE_EN build, word write with bvalid delayed 5 cycles -> data_data_ok one cycle after AW/W complete, next data_addr_ok only after bvalid.
